// File: rtl/quaddemux_buf4_pkg.sv
// Shared constants and helpers for the quaddemux_buf4 lane distributor.
package quaddemux_buf4_pkg;

   localparam int unsigned WIDTH_DEF = 4;
   localparam int unsigned NUM_LANES = 4;
   localparam int unsigned SEL_W     = 2;

   typedef logic [SEL_W-1:0]     lane_idx_t;
   typedef logic [NUM_LANES-1:0] lane_vec_t;

   localparam lane_idx_t LANE_A = 2'd0;
   localparam lane_idx_t LANE_B = 2'd1;
   localparam lane_idx_t LANE_C = 2'd2;
   localparam lane_idx_t LANE_D = 2'd3;

   // One-hot lane mask for a lane index.
   function automatic lane_vec_t lane_onehot(input lane_idx_t idx);
      lane_vec_t v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/quaddemux_buf4_demux_lane.sv
// One-entry lane buffer: holds a word until its consumer takes it.
module demux_lane
   import quaddemux_buf4_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             ready_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o
);

   logic [WIDTH-1:0] data_q,  data_d;
   logic             valid_q, valid_d;

   // A load in the same cycle as a drain wins, giving pass-through.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
      if (load_i) begin
         data_d  = data_i;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/quaddemux_buf4.sv
// Registered 1-to-4 lane distributor with explicit or round-robin steering.
module quaddemux_buf4
   import quaddemux_buf4_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     in_data,
   input  logic [SEL_W-1:0]     in_sel,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 rr_mode,
   output logic [SEL_W-1:0]     rr_ptr,
   output logic [WIDTH-1:0]     out_data_a,
   output logic [WIDTH-1:0]     out_data_b,
   output logic [WIDTH-1:0]     out_data_c,
   output logic [WIDTH-1:0]     out_data_d,
   output logic [NUM_LANES-1:0] out_valid,
   input  logic [NUM_LANES-1:0] out_ready
);

   lane_idx_t        tgt_c;
   lane_idx_t        rr_ptr_q, rr_ptr_d;
   lane_vec_t        load_c;
   lane_vec_t        valid_c;
   logic             ready_c;
   logic             accept_c;
   logic [WIDTH-1:0] lane_data [NUM_LANES];

   // Target select, ready (combinational through out_ready), load decode.
   always_comb begin
      tgt_c    = rr_mode ? rr_ptr_q : in_sel;
      ready_c  = ~valid_c[tgt_c] | out_ready[tgt_c];
      accept_c = in_valid & ready_c;
      load_c   = accept_c ? lane_onehot(tgt_c) : '0;
      rr_ptr_d = rr_ptr_q;
      if (accept_c && rr_mode) begin
         rr_ptr_d = lane_idx_t'(rr_ptr_q + 2'd1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= LANE_A;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      demux_lane #(.WIDTH(WIDTH)) u_lane (
         .clk     (clk),
         .rst     (rst),
         .load_i  (load_c[g]),
         .ready_i (out_ready[g]),
         .data_i  (in_data),
         .data_o  (lane_data[g]),
         .valid_o (valid_c[g])
      );
   end

   assign in_ready   = ready_c;
   assign rr_ptr     = rr_ptr_q;
   assign out_valid  = valid_c;
   assign out_data_a = lane_data[LANE_A];
   assign out_data_b = lane_data[LANE_B];
   assign out_data_c = lane_data[LANE_C];
   assign out_data_d = lane_data[LANE_D];

endmodule

// File: tb/tb_quaddemux_buf4.sv
// Self-checking bench for quaddemux_buf4: directed scenarios plus random traffic vs a lane model.
module tb_quaddemux_buf4;

   localparam int unsigned W = 4;

   logic         clk;
   logic         rst;
   logic [W-1:0] in_data;
   logic [1:0]   in_sel;
   logic         in_valid;
   logic         in_ready;
   logic         rr_mode;
   logic [1:0]   rr_ptr;
   logic [W-1:0] out_data_a, out_data_b, out_data_c, out_data_d;
   logic [3:0]   out_valid;
   logic [3:0]   out_ready;
   logic [W-1:0] dut_data [4];

   int checks = 0;
   int passes = 0;

   // Reference model: per-lane occupancy/word and a modulo-4 pointer.
   bit           m_valid [4];
   logic [W-1:0] m_data  [4];
   int           m_ptr;

   quaddemux_buf4 #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .rr_mode    (rr_mode),
      .rr_ptr     (rr_ptr),
      .out_data_a (out_data_a),
      .out_data_b (out_data_b),
      .out_data_c (out_data_c),
      .out_data_d (out_data_d),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   assign dut_data[0] = out_data_a;
   assign dut_data[1] = out_data_b;
   assign dut_data[2] = out_data_c;
   assign dut_data[3] = out_data_d;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int m_target();
      return rr_mode ? m_ptr : int'(in_sel);
   endfunction

   function automatic bit m_ready();
      int t;
      t = m_target();
      return !m_valid[t] || out_ready[t];
   endfunction

   function automatic logic [3:0] m_valid_vec();
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = m_valid[i];
      return v;
   endfunction

   // Advance one clock, updating the model from the inputs seen at the edge.
   task automatic step();
      int t;
      bit acc;
      t   = m_target();
      acc = in_valid && m_ready();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            m_valid[i] = 0;
            m_data[i]  = '0;
         end
         m_ptr = 0;
      end else begin
         for (int i = 0; i < 4; i++)
            if (m_valid[i] && out_ready[i]) m_valid[i] = 0;
         if (acc) begin
            m_valid[t] = 1;
            m_data[t]  = in_data;
            if (rr_mode) m_ptr = (m_ptr + 1) % 4;
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      in_valid  = 1'b0;
      in_data   = '0;
      in_sel    = 2'd0;
      rr_mode   = 1'b0;
      out_ready = 4'b0000;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (out_valid !== 4'b0000) $display("FAIL reset_valid got=%b exp=0000", out_valid); else passes++;
      checks++; if (rr_ptr !== 2'd0) $display("FAIL reset_ptr got=%0d exp=0", rr_ptr); else passes++;
      for (int i = 0; i < 4; i++) begin
         checks++; if (dut_data[i] !== '0) $display("FAIL reset_data lane=%0d got=%h exp=0", i, dut_data[i]); else passes++;
      end
      checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passes++;
   endtask

   task automatic test_explicit_steer();
      do_reset();
      in_valid = 1'b1; in_sel = 2'd2; in_data = 4'hA;
      step();
      in_sel = 2'd0; in_data = 4'h5;
      step();
      in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 4'b0101) $display("FAIL steer_valid got=%b exp=0101", out_valid); else passes++;
      checks++; if (out_data_c !== 4'hA) $display("FAIL steer_lane_c got=%h exp=a", out_data_c); else passes++;
      checks++; if (out_data_a !== 4'h5) $display("FAIL steer_lane_a got=%h exp=5", out_data_a); else passes++;
   endtask

   task automatic test_backpressure();
      do_reset();
      in_valid = 1'b1; in_sel = 2'd1; in_data = 4'h7;
      step();
      in_data = 4'h3;
      #1;
      checks++; if (in_ready !== 1'b0) $display("FAIL bp_stall_ready got=%b exp=0", in_ready); else passes++;
      step();
      checks++; if (out_data_b !== 4'h7 || out_valid[1] !== 1'b1)
         $display("FAIL bp_hold got=%h/%b exp=7/1", out_data_b, out_valid[1]); else passes++;
      out_ready = 4'b0010;
      #1;
      checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got=%b exp=1", in_ready); else passes++;
      step();
      in_valid = 1'b0; out_ready = 4'b0000;
      #1;
      checks++; if (out_data_b !== 4'h3 || out_valid[1] !== 1'b1)
         $display("FAIL bp_passthru got=%h/%b exp=3/1", out_data_b, out_valid[1]); else passes++;
   endtask

   task automatic test_rr_wrap();
      int exp_ptr [5] = '{0, 1, 2, 3, 0};
      logic [3:0] exp_vld;
      do_reset();
      rr_mode = 1'b1; out_ready = 4'b1111; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = W'(i + 1);
         in_sel  = 2'($urandom_range(3));
         #1;
         checks++; if (int'(rr_ptr) !== exp_ptr[i]) $display("FAIL rr_ptr idx=%0d got=%0d exp=%0d", i, rr_ptr, exp_ptr[i]); else passes++;
         step();
         exp_vld = 4'b0001 << (i % 4);
         checks++; if (dut_data[i % 4] !== W'(i + 1) || out_valid !== exp_vld)
            $display("FAIL rr_lane idx=%0d got=%h/%b exp=%h/%b", i, dut_data[i % 4], out_valid, W'(i + 1), exp_vld); else passes++;
      end
      in_valid = 1'b0;
      #1;
      checks++; if (rr_ptr !== 2'd1) $display("FAIL rr_final_ptr got=%0d exp=1", rr_ptr); else passes++;
   endtask

   task automatic test_stall_holds_ptr();
      do_reset();
      in_valid = 1'b1; in_sel = 2'd2; in_data = 4'h9;
      step();
      rr_mode = 1'b1; out_ready = 4'b0011; in_data = 4'h1;
      step();
      in_data = 4'h2;
      step();
      in_valid = 1'b0;
      step();
      out_ready = 4'b0000; in_valid = 1'b1; in_data = 4'hE;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (in_ready !== 1'b0 || rr_ptr !== 2'd2)
            $display("FAIL stall_ptr cyc=%0d got=%b/%0d exp=0/2", i, in_ready, rr_ptr); else passes++;
         step();
         checks++; if (out_valid !== 4'b0100 || out_data_c !== 4'h9)
            $display("FAIL stall_lanes cyc=%0d got=%b/%h exp=0100/9", i, out_valid, out_data_c); else passes++;
      end
      out_ready = 4'b0100;
      #1;
      checks++; if (in_ready !== 1'b1) $display("FAIL stall_release got=%b exp=1", in_ready); else passes++;
      step();
      in_valid = 1'b0; out_ready = 4'b0000;
      #1;
      checks++; if (rr_ptr !== 2'd3 || out_data_c !== 4'hE || out_valid !== 4'b0100)
         $display("FAIL stall_after got=%0d/%h/%b exp=3/e/0100", rr_ptr, out_data_c, out_valid); else passes++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      rr_mode = 1'b1; in_valid = 1'b1; in_data = 4'h1;
      step();
      rr_mode = 1'b0; in_sel = 2'd3; in_data = 4'h2;
      step();
      #1;
      checks++; if (out_valid !== 4'b1001 || rr_ptr !== 2'd1)
         $display("FAIL rstmid_pre got=%b/%0d exp=1001/1", out_valid, rr_ptr); else passes++;
      rst = 1'b1; in_sel = 2'd1; in_data = 4'hF; out_ready = 4'b1111;
      step();
      rst = 1'b0; idle_inputs();
      #1;
      checks++; if (out_valid !== 4'b0000 || rr_ptr !== 2'd0 || out_data_b !== 4'h0)
         $display("FAIL rstmid_post got=%b/%0d/%h exp=0000/0/0", out_valid, rr_ptr, out_data_b); else passes++;
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 400; n++) begin
         rst       = ($urandom_range(39) == 0);
         in_valid  = ($urandom_range(3) != 0);
         in_sel    = 2'($urandom_range(3));
         in_data   = W'($urandom);
         rr_mode   = ($urandom_range(1) == 1);
         out_ready = 4'($urandom);
         #1;
         checks++; if (in_ready !== m_ready()) $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, in_ready, m_ready()); else passes++;
         step();
         checks++; if (out_valid !== m_valid_vec() || int'(rr_ptr) !== m_ptr)
            $display("FAIL rnd_state n=%0d got=%b/%0d exp=%b/%0d", n, out_valid, rr_ptr, m_valid_vec(), m_ptr); else passes++;
         for (int i = 0; i < 4; i++) begin
            if (m_valid[i]) begin
               checks++; if (dut_data[i] !== m_data[i])
                  $display("FAIL rnd_data n=%0d lane=%0d got=%h exp=%h", n, i, dut_data[i], m_data[i]); else passes++;
            end
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      m_ptr = 0;
      for (int i = 0; i < 4; i++) begin
         m_valid[i] = 0;
         m_data[i]  = '0;
      end
      idle_inputs();
      test_reset();
      test_explicit_steer();
      test_backpressure();
      test_rr_wrap();
      test_stall_holds_ptr();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/quaddemux_buf4.md
# quaddemux_buf4

Registered 1-to-4 lane distributor, the inverse of the 4:1 lane select mux. It accepts one WIDTH-bit word per cycle over a valid/ready handshake. Each word is steered to one of four output lanes, chosen either by an explicit select or by an internal round-robin pointer. Each lane holds the word in a one-entry buffer until its consumer takes it. It sits between a single producer (decode/writeback path) and four independent consumers that may stall separately.

## Interface
- WIDTH, 4, data width of every lane.
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word offered by the producer.
- in_sel  input  2  target lane when rr_mode=0 (0→lane A … 3→lane D).
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept this cycle (combinational).
- rr_mode  input  1  1: target = rr_ptr, in_sel ignored; 0: target = in_sel.
- rr_ptr  output  2  current round-robin pointer.
- out_data_a / _b / _c / _d  output  WIDTH each  lane buffer contents.
- out_valid  output  4  bit i = lane i buffer full.
- out_ready  input  4  bit i = consumer i takes lane i this cycle.

## Operation
- Target lane t = rr_mode ? rr_ptr : in_sel, evaluated combinationally each cycle.
- Lane i drain: out_valid[i] & out_ready[i]. The buffer empties at the edge unless it is refilled at the same edge.
- in_ready = ~out_valid[t] | out_ready[t]. This is a combinational path from out_ready to in_ready, and it is permitted.
- Accept: in_valid & in_ready.
  - On accept, lane t loads in_data and out_valid[t] is 1 next cycle.
  - A simultaneous drain and accept on the same lane is pass-through. The old word leaves, the new word is loaded, and out_valid stays 1.
- Non-target lanes are unaffected by the input side.
- Drains on other lanes proceed independently in the same cycle.
- out_data_x holds its last loaded value after draining. It is only meaningful while out_valid=1.
- rr_ptr update:
  - Increments by 1 mod 4 (3→0 wraps) only on an accept while rr_mode=1.
  - Otherwise it holds.
  - Toggling rr_mode does not reset it.
- in_sel and in_data are ignored when in_valid=0.
- in_valid=1 with in_ready=0 (target full and not draining): nothing is written. The producer must hold its word; the block stores nothing on stall.

## Timing
- Reset (synchronous): out_valid=4'b0000, all out_data_x=0, rr_ptr=0. in_ready is therefore 1 in the first cycle after reset.
- Latency: a word accepted at edge k is visible on its lane from cycle k+1.
- Throughput: one word per cycle overall, and one word per cycle per lane when that consumer drains continuously.
- Reset asserted mid-operation discards every buffered word.
  - Accepts in the reset cycle are ignored.
  - Drains in the reset cycle have no effect beyond the reset state.
- All four lanes full with no out_ready: in_ready=0 for any target, and the state is frozen.
- rr_mode changing in the same cycle as an accept: the target uses the rr_mode value sampled that cycle.

## Structure
- Shared include holds the default WIDTH and lane index localparams (LANE_A=2'd0 … LANE_D=2'd3). The round-robin wrap needs no separate constant because the pointer is 2-bit.
- One sub-module: demux_lane, a one-entry buffer with load, drain, valid flag and a sync reset. It is instantiated four times.
- Top level contains the following, built from the existing mux2_1/dff primitives where practical:
  - the target select;
  - the ready logic;
  - the 2-bit rr_ptr register;
  - a one-hot load decode.

## Test plan
- Reset then idle: after rst high for 2 cycles → out_valid=0000, rr_ptr=0, out_data_a..d=0, in_ready=1.
- Explicit steer: rr_mode=0, send 4'hA sel=2 then 4'h5 sel=0, out_ready=0 → out_valid=0101, out_data_c=A, out_data_a=5.
- Backpressure: lane B full and out_ready[1]=0, send sel=1 4'h3 → in_ready=0, buffer still holds the old word. Raise out_ready[1] → in_ready=1 in the same cycle, and lane B=3 next cycle with out_valid[1] still 1.
- Round-robin wrap: rr_mode=1, out_ready=1111, stream 1,2,3,4,5 → lanes A,B,C,D,A receive them, rr_ptr sequence 0,1,2,3,0,1.
- Stall holds pointer: rr_mode=1, lane at rr_ptr=2 full, in_valid=1 → rr_ptr stays 2 until lane C drains, and no other lane is written.
- Reset mid-stream: lanes A and D full, assert rst with in_valid=1 sel=1 → next cycle out_valid=0000 and rr_ptr=0; lane B not loaded.
